// File: rtl/dt_node_walker.sv
`timescale 1ns/1ps
// dt_node_walker
//   Programmable sequential decision-tree classifier. A node table is loaded
//   through the cfg_* port while the engine is idle. Each accepted feature word
//   is walked from node 0 (the root), one node per clock, until a leaf is hit.
//   The leaf label is then returned on the out_* handshake.
//
// Ports
//   clk, rst_n          single clock, synchronous active-low reset
//   cfg_we/addr/wdata   node-table write, committed only while idle
//   cfg_ready           table writable (engine idle)
//   in_valid/in_ready   feature handshake, inp = feature bits
//   out_valid/out_ready result handshake, outp = leaf label, out_err = abort
//   busy                engine not idle
//   state_dbg           current FSM state, for observation only
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. A producer holds valid and its data stable until that
// edge. in_ready is high only in IDLE. out_valid, outp and out_err stay
// stable until the result is consumed.
//
// Node entry layout (LSB first): label[LABEL_W], left[NODE_AW],
// right[NODE_AW], feat_idx[4], is_leaf.
module dt_node_walker #(
  parameter int FEAT_W    = 14,
  parameter int LABEL_W   = 14,
  parameter int NODE_AW   = 7,
  parameter int MAX_DEPTH = 16,
  localparam int NW       = 5 + 2*NODE_AW + LABEL_W,
  localparam int DEPTH_W  = $clog2(MAX_DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [NODE_AW-1:0] cfg_addr,
  input  logic [NW-1:0]      cfg_wdata,
  output logic               cfg_ready,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FEAT_W-1:0]  inp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LABEL_W-1:0] outp,
  output logic               out_err,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NN = 2**NODE_AW;
  // Reset content of every entry: a leaf with label 0.
  localparam logic [NW-1:0] LEAF_ZERO = {1'b1, {(NW-1){1'b0}}};

  state_t               state;
  logic [NW-1:0]        tbl [NN];
  logic [NODE_AW-1:0]   node;
  logic [DEPTH_W-1:0]   depth;
  logic [FEAT_W-1:0]    inp_q;

  // Decoded view of the current node entry.
  logic [NW-1:0]        ent;
  logic                 ent_leaf;
  logic [3:0]           ent_feat;
  logic [NODE_AW-1:0]   ent_right;
  logic [NODE_AW-1:0]   ent_left;
  logic [LABEL_W-1:0]   ent_label;
  logic                 feat_ok;
  logic                 feat_bit;
  logic                 depth_last;

  always_comb begin
    ent       = tbl[node];
    ent_label = ent[LABEL_W-1:0];
    ent_left  = ent[LABEL_W +: NODE_AW];
    ent_right = ent[LABEL_W+NODE_AW +: NODE_AW];
    ent_feat  = ent[LABEL_W+2*NODE_AW +: 4];
    ent_leaf  = ent[NW-1];
  end

  assign feat_ok    = (32'(ent_feat) < FEAT_W);
  assign depth_last = (depth == DEPTH_W'(MAX_DEPTH-1));

  // Bit select through a compare loop so an out-of-range feat_idx never
  // indexes past inp_q; the result is only used when feat_ok is true.
  always_comb begin
    feat_bit = 1'b0;
    for (int i = 0; i < FEAT_W; i++) begin
      if (ent_feat == 4'(i)) feat_bit = inp_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      outp      <= '0;
      out_err   <= 1'b0;
      depth     <= '0;
      node      <= '0;
      inp_q     <= '0;
      for (int i = 0; i < NN; i++) tbl[i] <= LEAF_ZERO;
    end else begin
      case (state)
        IDLE: begin
          // A write on the accept edge lands before the walk's first read.
          if (cfg_we) tbl[cfg_addr] <= cfg_wdata;
          if (in_valid) begin
            inp_q <= inp;
            node  <= '0;
            depth <= '0;
            state <= WALK;
          end
        end
        WALK: begin
          if (ent_leaf) begin
            outp      <= ent_label;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (!feat_ok || depth_last) begin
            // Bad feature index, or the depth budget is spent (catches cycles).
            outp      <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            node  <= feat_bit ? ent_right : ent_left;
            depth <= depth + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_dt_node_walker.sv
`timescale 1ns/1ps
module tb_dt_node_walker;

  localparam int FEAT_W    = 14;
  localparam int LABEL_W   = 14;
  localparam int NODE_AW   = 7;
  localparam int MAX_DEPTH = 16;
  localparam int NW        = 5 + 2*NODE_AW + LABEL_W;
  localparam int NN        = 2**NODE_AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n = 1'b0;
  logic               cfg_we = 1'b0;
  logic [NODE_AW-1:0] cfg_addr = '0;
  logic [NW-1:0]      cfg_wdata = '0;
  logic               cfg_ready;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [FEAT_W-1:0]  inp = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [LABEL_W-1:0] outp;
  logic               out_err;
  logic               busy;
  logic [1:0]         state_dbg;

  dt_node_walker #(
    .FEAT_W(FEAT_W), .LABEL_W(LABEL_W), .NODE_AW(NODE_AW), .MAX_DEPTH(MAX_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready),
    .in_valid(in_valid), .in_ready(in_ready), .inp(inp),
    .out_valid(out_valid), .out_ready(out_ready), .outp(outp), .out_err(out_err),
    .busy(busy), .state_dbg(state_dbg)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model: the tree as plain arrays ----------------
  bit                 m_leaf  [NN];
  logic [3:0]         m_feat  [NN];
  logic [NODE_AW-1:0] m_right [NN];
  logic [NODE_AW-1:0] m_left  [NN];
  logic [LABEL_W-1:0] m_label [NN];

  function automatic logic [NW-1:0] pk(input bit leaf, input logic [3:0] f,
                                       input logic [NODE_AW-1:0] r,
                                       input logic [NODE_AW-1:0] l,
                                       input logic [LABEL_W-1:0] lab);
    return {leaf, f, r, l, lab};
  endfunction

  task automatic m_write(input logic [NODE_AW-1:0] a, input logic [NW-1:0] w);
    m_label[a] = w[13:0];
    m_left[a]  = w[20:14];
    m_right[a] = w[27:21];
    m_feat[a]  = w[31:28];
    m_leaf[a]  = w[32];
  endtask

  task automatic m_reset();
    for (int i = 0; i < NN; i++) m_write(NODE_AW'(i), pk(1'b1, 4'd0, '0, '0, '0));
  endtask

  // Walk the tree: returns label, error flag and cycles from accept to out_valid.
  task automatic model_walk(input logic [FEAT_W-1:0] x, output logic [LABEL_W-1:0] lab,
                            output bit err, output int lat);
    int nd;
    nd  = 0;
    lab = '0;
    err = 1'b1;
    lat = MAX_DEPTH;
    for (int d = 0; d < MAX_DEPTH; d++) begin
      if (m_leaf[nd]) begin
        lab = m_label[nd]; err = 1'b0; lat = d + 1; return;
      end
      if (m_feat[nd] >= FEAT_W) begin
        lab = '0; err = 1'b1; lat = d + 1; return;
      end
      nd = x[m_feat[nd]] ? int'(m_right[nd]) : int'(m_left[nd]);
    end
  endtask

  // ---------------- scoreboard helper ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cfg(input logic [NODE_AW-1:0] a, input logic [NW-1:0] w);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = w;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    m_write(a, w);
  endtask

  // One transaction. same_wr: cfg write on the accept edge (caller updates the
  // model first). walk_wr: cfg write held while busy (must be dropped).
  task automatic run(input string tag, input logic [FEAT_W-1:0] x,
                     input bit same_wr, input bit walk_wr,
                     input logic [NODE_AW-1:0] waddr, input logic [NW-1:0] wdata,
                     input bit consume);
    logic [LABEL_W-1:0] el;
    bit                 ee;
    int                 elat;
    int                 lat;
    model_walk(x, el, ee, elat);
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; inp = x;
    if (same_wr) begin cfg_we = 1'b1; cfg_addr = waddr; cfg_wdata = wdata; end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0;
    if (walk_wr) begin cfg_we = 1'b1; cfg_addr = waddr; cfg_wdata = wdata; end
    check({tag, ".busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 64) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    cfg_we = 1'b0;
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".latency"}, 32'(lat), 32'(elat));
    check({tag, ".outp"}, 32'(outp), 32'(el));
    check({tag, ".out_err"}, 32'(out_err), 32'(ee));
    if (consume) begin
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, ".drained"}, 32'(out_valid), 32'd0);
      check({tag, ".idle"}, 32'(in_ready), 32'd1);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [NW-1:0]      w;
    logic [NODE_AW-1:0] a;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.outp", 32'(outp), 32'd0);
    check("rst.out_err", 32'(out_err), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.cfg_ready", 32'(cfg_ready), 32'd1);
    run("unprog", 14'(($urandom())), 1'b0, 1'b0, '0, '0, 1'b1);

    // out_ready while idle does nothing
    @(negedge clk);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    check("idle_ready.out_valid", 32'(out_valid), 32'd0);
    check("idle_ready.in_ready", 32'(in_ready), 32'd1);

    // T1 basic tree
    cfg(7'd0, pk(1'b0, 4'd10, 7'd2, 7'd1, 14'h0));
    cfg(7'd1, pk(1'b1, 4'd0, 7'd0, 7'd0, 14'h0103));
    cfg(7'd2, pk(1'b1, 4'd0, 7'd0, 7'd0, 14'h2108));
    run("t1.right", 14'h0400, 1'b0, 1'b0, '0, '0, 1'b1);
    run("t1.left", 14'h0000, 1'b0, 1'b0, '0, '0, 1'b1);

    // T2 backpressure
    run("t2", 14'h0400, 1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2.hold.out_valid", 32'(out_valid), 32'd1);
      check("t2.hold.outp", 32'(outp), 32'h2108);
      check("t2.hold.in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("t2.release.in_ready", 32'(in_ready), 32'd1);
    check("t2.release.out_valid", 32'(out_valid), 32'd0);

    // T3 self loop hits the depth limit
    cfg(7'd0, pk(1'b0, 4'd0, 7'd0, 7'd0, 14'h0));
    run("t3.loop", 14'h0000, 1'b0, 1'b0, '0, '0, 1'b1);

    // T4 bad feature index, with a write during the walk that must be dropped
    cfg(7'd0, pk(1'b0, 4'd15, 7'd2, 7'd1, 14'h0));
    run("t4.badfeat", 14'h0400, 1'b0, 1'b1, 7'd2, pk(1'b1, 4'd0, 7'd0, 7'd0, 14'h3FFF), 1'b1);
    cfg(7'd0, pk(1'b0, 4'd10, 7'd2, 7'd1, 14'h0));
    run("t4.rerun", 14'h0400, 1'b0, 1'b0, '0, '0, 1'b1);

    // T5 write and accept on the same edge
    w = pk(1'b1, 4'd0, 7'd0, 7'd0, 14'h0001);
    m_write(7'd2, w);
    run("t5.same_edge", 14'h0400, 1'b1, 1'b0, 7'd2, w, 1'b1);

    // T6 reset in the middle of a walk
    cfg(7'd0, pk(1'b0, 4'd0, 7'd0, 7'd0, 14'h0));
    @(negedge clk);
    in_valid = 1'b1; inp = '0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    check("t6.out_valid", 32'(out_valid), 32'd0);
    check("t6.busy", 32'(busy), 32'd0);
    check("t6.outp", 32'(outp), 32'd0);
    check("t6.out_err", 32'(out_err), 32'd0);
    run("t6.after", 14'($urandom()), 1'b0, 1'b0, '0, '0, 1'b1);

    // Random trees against the model
    for (int t = 0; t < 4; t++) begin
      for (int n = 0; n < 24; n++) begin
        a = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, NN-1)) : 7'($urandom_range(0, 15));
        w = pk(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
               7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)), 14'($urandom()));
        cfg(a, w);
      end
      for (int k = 0; k < 16; k++) begin
        if ($urandom_range(0, 7) == 0) begin
          a = 7'($urandom_range(0, 15));
          w = pk(1'b1, 4'd0, 7'd0, 7'd0, 14'($urandom()));
          m_write(a, w);
          run("rand.same_edge", 14'($urandom()), 1'b1, 1'b0, a, w, 1'b1);
        end else begin
          run("rand", 14'($urandom()), 1'b0, 1'b0, '0, '0, 1'b1);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
